serial_subtractor: RTL and testbench

- Bit-serial W-bit subtractor. Computes A - B - borrow_in LSB-first, one bit per clock, using a single 1-bit full-subtractor cell and a borrow flip-flop.
- Complements the combinational full-adder datapath: the subtract direction of the same arithmetic, in a low-area sequential form.
- Used by the team's serial ALU and as a directed-verification target.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller state encoding
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor: computes a_in - b_in - c_in.
//   a_in, b_in  : operand bits
//   c_in        : incoming borrow
//   diff_out    : difference bit
//   borrow_out  : outgoing borrow
module full_subtractor (
   input  logic a_in,
   input  logic b_in,
   input  logic c_in,
   output logic diff_out,
   output logic borrow_out
);

   assign diff_out   = a_in ^ b_in ^ c_in;
   assign borrow_out = (~a_in & b_in) | (~(a_in ^ b_in) & c_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B - borrow_in, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flip-flop.
//   clock, resetn   : system clock, async active-low reset
//   start_in        : begin an operation (honoured only in IDLE)
//   a_in, b_in      : minuend / subtrahend, captured on start
//   borrow_in       : initial borrow, captured on start
//   busy_out        : operation in progress
//   bit_valid_out   : qualifies diff_bit_out
//   diff_bit_out    : serial difference bit
//   done_out        : one-cycle result-valid pulse
//   diff_out        : parallel difference (held until next result)
//   borrow_out      : final borrow (unsigned A < B + borrow_in)
//   overflow_out    : two's-complement overflow
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | waiting for start_in; results hold
// ST_RUN  | one difference bit per cycle, WIDTH cycles
// ST_DONE | one cycle, done_out high, results valid
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy_out,
   output logic             bit_valid_out,
   output logic             diff_bit_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out,
   output logic             overflow_out
);

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             br_q, a_msb_q, b_msb_q;
   logic [CW-1:0]    cnt;
   logic             cell_d, cell_br;
   logic             run;

   full_subtractor u_cell (
      .a_in       (a_sr[0]),
      .b_in       (b_sr[0]),
      .c_in       (br_q),
      .diff_out   (cell_d),
      .borrow_out (cell_br)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      run           = 1'b0;
      done_out      = 1'b0;
      case (state)
         ST_IDLE: if (start_in) state_nxt = ST_RUN;
         ST_RUN: begin
            run = 1'b1;
            if (cnt == LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_out  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_out      = run;
      bit_valid_out = run;
      diff_bit_out  = run & cell_d;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_sr         <= '0;
         b_sr         <= '0;
         res_sr       <= '0;
         br_q         <= 1'b0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         cnt          <= '0;
         diff_out     <= '0;
         borrow_out   <= 1'b0;
         overflow_out <= 1'b0;
      end else if (state == ST_IDLE && start_in) begin
         a_sr    <= a_in;
         b_sr    <= b_in;
         br_q    <= borrow_in;
         a_msb_q <= a_in[WIDTH-1];
         b_msb_q <= b_in[WIDTH-1];
         cnt     <= '0;
      end else if (run) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {cell_d, res_sr[WIDTH-1:1]};
         br_q   <= cell_br;
         cnt    <= cnt + 1'b1;
         // Results are published on the last RUN edge so they are already
         // registered for the whole DONE cycle; the last cell bit is the MSB.
         if (cnt == LAST) begin
            diff_out     <= {cell_d, res_sr[WIDTH-1:1]};
            borrow_out   <= cell_br;
            overflow_out <= (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clock = 1'b0;
   logic         resetn = 1'b1;
   logic         start_in = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         borrow_in = 1'b0;
   logic         busy_out, bit_valid_out, diff_bit_out, done_out;
   logic [W-1:0] diff_out;
   logic         borrow_out, overflow_out;

   serial_subtractor #(.WIDTH(W)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .start_in      (start_in),
      .a_in          (a_in),
      .b_in          (b_in),
      .borrow_in     (borrow_in),
      .busy_out      (busy_out),
      .bit_valid_out (bit_valid_out),
      .diff_bit_out  (diff_bit_out),
      .done_out      (done_out),
      .diff_out      (diff_out),
      .borrow_out    (borrow_out),
      .overflow_out  (overflow_out)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int accepted = 0;
   int dones = 0;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   logic bit_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input int a, input int b, input int bin, input int c);
      exp_t r;
      int d, sa, sb, sd;
      d  = a - b - bin;
      sa = (a >= 2**(W-1)) ? a - 2**W : a;
      sb = (b >= 2**(W-1)) ? b - 2**W : b;
      sd = sa - sb - bin;
      r.diff   = W'(d);
      r.borrow = (d < 0);
      r.ovf    = (sd < -(2**(W-1))) || (sd > 2**(W-1) - 1);
      r.cyc    = c;
      return r;
   endfunction

   // Monitor: compares whatever the DUT presents against the queued expectations.
   initial begin
      exp_t e;
      logic eb;
      forever begin
         @(posedge clock);
         #1;
         if (bit_valid_out) begin
            if (bit_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_bit: got bit_valid_out=1 expected no serial bit (t=%0t)", $time);
            end else begin
               eb = bit_q.pop_front();
               check("diff_bit", diff_bit_out, eb);
               check("busy_run", busy_out, 1);
            end
         end else begin
            check("busy_idle", busy_out, 0);
         end
         if (done_out) begin
            dones++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_done: got done_out=1 expected no result (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("diff_out", diff_out, e.diff);
               check("borrow_out", borrow_out, e.borrow);
               check("overflow_out", overflow_out, e.ovf);
               check("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic randomize_inputs(input bit rand_start);
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      borrow_in = 1'($urandom);
      if (rand_start) start_in = 1'($urandom);
   endtask

   // Issues one operation after 'gap' idle cycles, then drives garbage
   // (including start_in) for the remaining WIDTH+1 cycles of the operation.
   task automatic do_op(input int a, input int b, input int bin, input int gap);
      exp_t r;
      for (int i = 0; i < gap; i++) begin
         @(negedge clock);
         start_in = 1'b0;
         randomize_inputs(0);
      end
      @(negedge clock);
      a_in      = W'(a);
      b_in      = W'(b);
      borrow_in = 1'(bin);
      start_in  = 1'b1;
      r = model(a, b, bin, cyc + 1 + W);
      exp_q.push_back(r);
      for (int i = 0; i < W; i++) bit_q.push_back(r.diff[i]);
      accepted++;
      repeat (W + 1) begin
         @(negedge clock);
         randomize_inputs(1);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_bit_valid"}, bit_valid_out, 0);
      check({tag, "_diff_bit"}, diff_bit_out, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_diff"}, diff_out, 0);
      check({tag, "_borrow"}, borrow_out, 0);
      check({tag, "_ovf"}, overflow_out, 0);
   endtask

   initial begin
      exp_t r;
      #2 resetn = 1'b0;
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      resetn = 1'b1;

      // directed cases
      do_op(7, 3, 0, 2);
      do_op(3, 7, 0, 1);
      do_op(8, 1, 0, 3);
      do_op(5, 2, 1, 0);
      do_op(0, 0, 1, 0);

      // exhaustive sweep, back-to-back with start held high
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               do_op(a, b, c, 0);

      // random operands with random idle gaps
      for (int i = 0; i < 40; i++)
         do_op(int'($urandom_range(15)), int'($urandom_range(15)),
               int'($urandom_range(1)), int'($urandom_range(3)));

      // abort mid-RUN with reset
      @(negedge clock);
      a_in = 4'd9; b_in = 4'd3; borrow_in = 1'b0; start_in = 1'b1;
      r = model(9, 3, 0, 0);
      bit_q.push_back(r.diff[0]);
      bit_q.push_back(r.diff[1]);
      @(negedge clock);
      start_in = 1'b0;
      @(negedge clock);
      resetn = 1'b0;
      #1;
      check_outputs_zero("abort");
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (W + 4) @(negedge clock);
      check("abort_idle_busy", busy_out, 0);
      check("abort_bits_consumed", bit_q.size(), 0);

      // normal operation after the abort
      do_op(12, 5, 1, 1);
      @(negedge clock);
      start_in = 1'b0;
      repeat (W + 4) @(negedge clock);

      check("pending_results", exp_q.size(), 0);
      check("pending_bits", bit_q.size(), 0);
      check("done_count", dones, accepted);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
